// File: rtl/ushift_engine_if.sv
// rtl/ushift_engine_if.sv - command/result bundle for ushift_engine
interface ushift_engine_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [AMT_W-1:0] amt;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             cout;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, amt, sin,
    input  q, cout, busy, done
  );

  modport slave (
    input  start, op, a, amt, sin,
    output q, cout, busy, done
  );
endinterface

// File: rtl/ushift_engine.sv
// rtl/ushift_engine.sv - shift/rotate register, one step per cycle by default
// Defining USHIFT_BARREL_EN completes every shift/rotate at the accept edge.
module ushift_engine #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic          clk,
  input  logic          reset,
  ushift_engine_if.slave bus
);
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic             cout_r, cout_n;
  logic             done_r, done_n;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic [2:0]       op_r, op_n;
  logic             sin_r, sin_n;

  // Returns {cout, q} after a single step; non-shift codes pass through.
  function automatic logic [WIDTH:0] step(input logic [2:0] o,
                                          input logic [WIDTH-1:0] v,
                                          input logic s,
                                          input logic c);
    case (o)
      OP_SLL:  step = {v[WIDTH-1], v[WIDTH-2:0], s};
      OP_SRL:  step = {v[0], s, v[WIDTH-1:1]};
      OP_SRA:  step = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      OP_ROL:  step = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  step = {v[0], v[0], v[WIDTH-1:1]};
      default: step = {c, v};
    endcase
  endfunction

  function automatic logic is_shift(input logic [2:0] o);
    is_shift = (o >= OP_SLL) && (o <= OP_ROR);
  endfunction

`ifdef USHIFT_BARREL_EN
  localparam int STEPS = 1 << AMT_W;
  logic [WIDTH:0] barrel;

  // Unrolled chain of steps keeps the result bit-identical to the sequential build.
  always_comb begin
    barrel = {cout_r, q_r};
    for (int i = 0; i < STEPS; i++) begin
      if (AMT_W'(i) < bus.amt) begin
        barrel = step(bus.op, barrel[WIDTH-1:0], bus.sin, barrel[WIDTH]);
      end
    end
  end
`endif

  always_comb begin
    state_n = state;
    q_n     = q_r;
    cout_n  = cout_r;
    done_n  = 1'b0;
    cnt_n   = cnt;
    op_n    = op_r;
    sin_n   = sin_r;
    case (state)
      IDLE: begin
        if (bus.start) begin
          op_n  = bus.op;
          sin_n = bus.sin;
          cnt_n = bus.amt;
          if (bus.op == OP_LOAD) begin
            q_n    = bus.a;
            done_n = 1'b1;
          end else if (is_shift(bus.op) && (bus.amt != '0)) begin
`ifdef USHIFT_BARREL_EN
            {cout_n, q_n} = barrel;
            done_n        = 1'b1;
`else
            state_n = SHIFT;
`endif
          end else begin
            done_n = 1'b1;
          end
        end
      end
      SHIFT: begin
        {cout_n, q_n} = step(op_r, q_r, sin_r, cout_r);
        cnt_n         = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      q_r    <= '0;
      cout_r <= 1'b0;
      done_r <= 1'b0;
      cnt    <= '0;
      op_r   <= '0;
      sin_r  <= 1'b0;
    end else begin
      state  <= state_n;
      q_r    <= q_n;
      cout_r <= cout_n;
      done_r <= done_n;
      cnt    <= cnt_n;
      op_r   <= op_n;
      sin_r  <= sin_n;
    end
  end

  assign bus.q    = q_r;
  assign bus.cout = cout_r;
  assign bus.done = done_r;
  assign bus.busy = (state == SHIFT);
endmodule

// File: tb/tb_ushift_engine.sv
// tb/tb_ushift_engine.sv - scoreboard bench for ushift_engine
module tb_ushift_engine;
  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_HLD7 = 3'b111;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic       cout;
    int         cyc;
    int         busy;
  } exp_t;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } probe_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   busy_cnt = 0;
  bit   finish_req = 1'b0;
  exp_t   done_q[$];
  probe_t probe_q[$];

  ushift_engine_if #(.WIDTH(8), .AMT_W(3)) bus ();

  ushift_engine #(.WIDTH(8), .AMT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input logic [2:0] o, input logic [2:0] am);
`ifdef USHIFT_BARREL_EN
    lat = 0;
`else
    lat = (o >= OP_SLL && o <= OP_ROR) ? int'(am) : 0;
`endif
  endfunction

  task automatic start_op(input string nm, input logic [2:0] o, input logic [7:0] av,
                          input logic [2:0] am, input logic s,
                          input logic [7:0] eq, input logic ec, input bit expect_done);
    exp_t e;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = av;
    bus.amt   = am;
    bus.sin   = s;
    if (expect_done) begin
      e.name = nm; e.q = eq; e.cout = ec;
      e.cyc  = cyc + 1 + lat(o, am);
      e.busy = lat(o, am);
      done_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = 8'hEE;
  endtask

  task automatic run(input string nm, input logic [2:0] o, input logic [7:0] av,
                     input logic [2:0] am, input logic s, input logic [7:0] eq, input logic ec);
    start_op(nm, o, av, am, s, eq, ec, 1'b1);
    repeat (lat(o, am) + 1) @(posedge clk);
  endtask

  task automatic probe(input string nm, input logic [7:0] eq, input logic eb, input logic ed);
    probe_t p;
    p.name = nm; p.q = eq; p.busy = eb; p.done = ed;
    probe_q.push_back(p);
  endtask

  // Monitor: all comparisons happen here, away from the rising edge.
  always @(negedge clk) begin
    probe_t p;
    exp_t   e;
    if (!reset) busy_cnt = 0;
    else if (bus.busy) busy_cnt++;
    if (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      tests += 3;
      if (bus.q !== p.q) begin fails++; $display("FAIL %s q: got %h want %h", p.name, bus.q, p.q); end
      if (bus.busy !== p.busy) begin fails++; $display("FAIL %s busy: got %b want %b", p.name, bus.busy, p.busy); end
      if (bus.done !== p.done) begin fails++; $display("FAIL %s done: got %b want %b", p.name, bus.done, p.done); end
    end
    if (bus.done === 1'b1) begin
      tests++;
      if (done_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 want 0", cyc);
      end else begin
        e = done_q.pop_front();
        tests += 3;
        if (bus.q !== e.q) begin fails++; $display("FAIL %s q: got %h want %h", e.name, bus.q, e.q); end
        if (bus.cout !== e.cout) begin fails++; $display("FAIL %s cout: got %b want %b", e.name, bus.cout, e.cout); end
        if (cyc != e.cyc) begin fails++; $display("FAIL %s done_cycle: got %0d want %0d", e.name, cyc, e.cyc); end
        if (busy_cnt != e.busy) begin fails++; $display("FAIL %s busy_cycles: got %0d want %0d", e.name, busy_cnt, e.busy); end
      end
      busy_cnt = 0;
    end else if (done_q.size() > 0 && cyc > done_q[0].cyc) begin
      e = done_q.pop_front();
      tests++; fails++;
      $display("FAIL %s missing_done: got none by cycle %0d want at %0d", e.name, cyc, e.cyc);
    end
    if (finish_req) begin
      tests++;
      if (done_q.size() != 0 || probe_q.size() != 0) begin
        fails++;
        $display("FAIL drain: got %0d pending want 0", done_q.size() + probe_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b1;
    bus.op    = OP_LOAD;
    bus.a     = 8'hFF;
    bus.amt   = 3'd0;
    bus.sin   = 1'b0;
    reset     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    probe("reset_state", 8'h00, 1'b0, 1'b0);
    bus.start = 1'b0;
    reset     = 1'b1;
    @(posedge clk);

    run("load_b3",   OP_LOAD, 8'hB3, 3'd0, 1'b0, 8'hB3, 1'b0);
    run("sll3_sin1", OP_SLL,  8'h00, 3'd3, 1'b1, 8'h9F, 1'b1);
    run("load_5a",   OP_LOAD, 8'h5A, 3'd0, 1'b0, 8'h5A, 1'b1);
    run("srl0",      OP_SRL,  8'h00, 3'd0, 1'b1, 8'h5A, 1'b1);
    run("load_80",   OP_LOAD, 8'h80, 3'd0, 1'b0, 8'h80, 1'b1);
    run("sra7",      OP_SRA,  8'h00, 3'd7, 1'b1, 8'hFF, 1'b0);
    run("load_b3b",  OP_LOAD, 8'hB3, 3'd0, 1'b0, 8'hB3, 1'b0);
    run("ror4",      OP_ROR,  8'h00, 3'd4, 1'b1, 8'h3B, 1'b0);
    run("hold000",   OP_HOLD, 8'h11, 3'd5, 1'b1, 8'h3B, 1'b0);
    run("hold111",   OP_HLD7, 8'h22, 3'd2, 1'b0, 8'h3B, 1'b0);
    run("sll7_sin0", OP_SLL,  8'h00, 3'd7, 1'b0, 8'h80, 1'b1);
    run("rol7",      OP_ROL,  8'h00, 3'd7, 1'b0, 8'h40, 1'b0);
    run("srl2_sin1", OP_SRL,  8'h00, 3'd2, 1'b1, 8'hD0, 1'b0);

    run("load_b3c",  OP_LOAD, 8'hB3, 3'd0, 1'b0, 8'hB3, 1'b0);
`ifdef USHIFT_BARREL_EN
    run("rol5",      OP_ROL,  8'h00, 3'd5, 1'b0, 8'h76, 1'b0);
`else
    // A LOAD issued mid-shift must be dropped without a done pulse.
    start_op("rol5_ign", OP_ROL, 8'h00, 3'd5, 1'b0, 8'h76, 1'b0, 1'b1);
    bus.start = 1'b1; bus.op = OP_LOAD; bus.a = 8'h00;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);

    run("load_b3d",  OP_LOAD, 8'hB3, 3'd0, 1'b0, 8'hB3, 1'b0);
    start_op("rol5_abort", OP_ROL, 8'h00, 3'd5, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    probe("abort_state", 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (8) @(posedge clk);
`endif
    run("load_0f",   OP_LOAD, 8'h0F, 3'd0, 1'b0, 8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    finish_req = 1'b1;
  end
endmodule
